// File: rtl/multiport_functional_memory_pkg.sv
// Shared types and helpers for the multiport functional memory.
// Per-port FSM state encoding and latency counter sizing.
package multiport_functional_memory_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } port_state_t;

  // Bits needed to hold max(rd, wr); never less than one bit.
  function automatic int lat_cnt_width(input int rd, input int wr);
    int m;
    int w;
    m = (rd > wr) ? rd : wr;
    w = 1;
    while ((1 << w) < (m + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/multiport_functional_memory_port_ctrl.sv
// One request port: IDLE -> RD_WAIT | WR_WAIT -> IDLE with a latency down-counter.
// Valid/ready: a request is taken on an edge where the port is IDLE and its strobe is high.
module multiport_functional_memory_port_ctrl
  import multiport_functional_memory_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 8,
  parameter int RL = 9,
  parameter int WL = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] address,
  input  logic          address_valid,
  input  logic [DW-1:0] write_data,
  input  logic          write_data_valid,
  input  logic          read_write_select,
  input  logic [DW-1:0] mem_word,
  output logic [DW-1:0] read_data,
  output logic          read_data_valid,
  output logic          write_done,
  output logic          port_ready,
  output logic          commit_we,
  output logic [AW-1:0] commit_addr,
  output logic [DW-1:0] commit_data,
  output logic          read_strobe,
  output port_state_t   state
);

  localparam int CW = lat_cnt_width(RL, WL);

  port_state_t   state_next;
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          accept_rd;
  logic          accept_wr;
  logic          cnt_zero;

  always_comb begin
    cnt_zero   = (cnt == '0);
    accept_rd  = (state == IDLE) && address_valid && !read_write_select;
    accept_wr  = (state == IDLE) && address_valid && read_write_select && write_data_valid;
    state_next = state;
    case (state)
      IDLE: begin
        if (accept_rd)      state_next = RD_WAIT;
        else if (accept_wr) state_next = WR_WAIT;
      end
      RD_WAIT, WR_WAIT: begin
        if (cnt_zero) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign commit_we   = (state == WR_WAIT) && cnt_zero;
  assign read_strobe = (state == RD_WAIT) && cnt_zero;
  assign commit_addr = addr_q;
  assign commit_data = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      addr_q          <= '0;
      data_q          <= '0;
      read_data       <= '0;
      read_data_valid <= 1'b0;
      write_done      <= 1'b0;
      port_ready      <= 1'b1;
    end else begin
      state      <= state_next;
      write_done <= 1'b0;
      if (accept_rd || accept_wr) begin
        addr_q          <= address;
        data_q          <= write_data;
        cnt             <= accept_rd ? CW'(RL) : CW'(WL);
        read_data_valid <= 1'b0;
        port_ready      <= 1'b0;
      end else if (state != IDLE) begin
        if (!cnt_zero) begin
          cnt <= cnt - 1'b1;
        end else begin
          port_ready <= 1'b1;
          if (read_strobe) begin
            read_data       <= mem_word;
            read_data_valid <= 1'b1;
          end else begin
            write_done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/multiport_functional_memory.sv
// NUM_PORTS independent latency-modelled ports over one shared word array.
// Optional macro MULTIPORT_FUNCTIONAL_MEMORY_CLEAR_ON_RESET_EN zeroes the array on reset.
module multiport_functional_memory
  import multiport_functional_memory_pkg::*;
#(
  parameter int NUM_PORTS     = 2,
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 8,
  parameter int READ_LATENCY  = 9,
  parameter int WRITE_LATENCY = 14
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] address_i,
  input  logic [NUM_PORTS-1:0]              address_valid_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   write_data_i,
  input  logic [NUM_PORTS-1:0]              write_data_valid_i,
  input  logic [NUM_PORTS-1:0]              read_write_select_i,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]   read_data_o,
  output logic [NUM_PORTS-1:0]              read_data_valid_o,
  output logic [NUM_PORTS-1:0]              write_done_o,
  output logic [NUM_PORTS-1:0]              port_ready_o,
  output logic [NUM_PORTS*2-1:0]            port_state_o
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0]    mem         [DEPTH];
  logic                     commit_we   [NUM_PORTS];
  logic [ADDRESS_WIDTH-1:0] commit_addr [NUM_PORTS];
  logic [DATA_WIDTH-1:0]    commit_data [NUM_PORTS];
  logic                     read_strobe [NUM_PORTS];
  logic [DATA_WIDTH-1:0]    mem_word    [NUM_PORTS];
  port_state_t              state_p     [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    // Array read is taken at the completing edge, so a same-edge write is not yet visible.
    assign mem_word[p] = read_strobe[p] ? mem[commit_addr[p]] : '0;
    assign port_state_o[p*2 +: 2] = state_p[p];

    multiport_functional_memory_port_ctrl #(
      .DW(DATA_WIDTH),
      .AW(ADDRESS_WIDTH),
      .RL(READ_LATENCY),
      .WL(WRITE_LATENCY)
    ) u_ctrl (
      .clk               (clk_i),
      .rst_n             (reset_n_i),
      .address           (address_i[p*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
      .address_valid     (address_valid_i[p]),
      .write_data        (write_data_i[p*DATA_WIDTH +: DATA_WIDTH]),
      .write_data_valid  (write_data_valid_i[p]),
      .read_write_select (read_write_select_i[p]),
      .mem_word          (mem_word[p]),
      .read_data         (read_data_o[p*DATA_WIDTH +: DATA_WIDTH]),
      .read_data_valid   (read_data_valid_o[p]),
      .write_done        (write_done_o[p]),
      .port_ready        (port_ready_o[p]),
      .commit_we         (commit_we[p]),
      .commit_addr       (commit_addr[p]),
      .commit_data       (commit_data[p]),
      .read_strobe       (read_strobe[p]),
      .state             (state_p[p])
    );
  end

  // Highest port first so the lowest index is the last assignment and wins.
`ifdef MULTIPORT_FUNCTIONAL_MEMORY_CLEAR_ON_RESET_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
        if (commit_we[p]) mem[commit_addr[p]] <= commit_data[p];
      end
    end
  end
`else
  always_ff @(posedge clk_i) begin
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (commit_we[p]) mem[commit_addr[p]] <= commit_data[p];
    end
  end
`endif

endmodule

// File: tb/tb_multiport_functional_memory.sv
// Directed bench for multiport_functional_memory with an expected-read queue.
module tb_multiport_functional_memory;

  localparam int NP = 2;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int RL = 9;
  localparam int WL = 14;

  logic             clk;
  logic             reset_n;
  logic [NP*AW-1:0] address_i;
  logic [NP-1:0]    address_valid_i;
  logic [NP*DW-1:0] write_data_i;
  logic [NP-1:0]    write_data_valid_i;
  logic [NP-1:0]    read_write_select_i;
  logic [NP*DW-1:0] read_data_o;
  logic [NP-1:0]    read_data_valid_o;
  logic [NP-1:0]    write_done_o;
  logic [NP-1:0]    port_ready_o;
  logic [NP*2-1:0]  port_state_o;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  multiport_functional_memory #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
    .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk_i               (clk),
    .reset_n_i           (reset_n),
    .address_i           (address_i),
    .address_valid_i     (address_valid_i),
    .write_data_i        (write_data_i),
    .write_data_valid_i  (write_data_valid_i),
    .read_write_select_i (read_write_select_i),
    .read_data_o         (read_data_o),
    .read_data_valid_o   (read_data_valid_o),
    .write_done_o        (write_done_o),
    .port_ready_o        (port_ready_o),
    .port_state_o        (port_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive(input int p, input logic rw, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic dv);
    address_i[p*AW +: AW]    = a;
    write_data_i[p*DW +: DW] = d;
    read_write_select_i[p]   = rw;
    write_data_valid_i[p]    = dv;
    address_valid_i[p]       = 1'b1;
  endtask

  task automatic release_port(input int p);
    address_valid_i[p]    = 1'b0;
    write_data_valid_i[p] = 1'b0;
  endtask

  task automatic wait_done(input int p, input string tag);
    int n;
    n = 0;
    while (!write_done_o[p] && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 32'(write_done_o[p]), 32'd1);
    tick();
    check({tag, "_pulse"}, 32'(write_done_o[p]), 32'd0);
  endtask

  task automatic do_write(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input string tag);
    drive(p, 1'b1, a, d, 1'b1);
    tick();
    release_port(p);
    wait_done(p, tag);
  endtask

  // scoreboard pop and compare on read completion
  task automatic wait_read(input int p, input string tag);
    int n;
    logic [DW-1:0] e;
    n = 0;
    while (!read_data_valid_o[p] && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(read_data_valid_o[p]), 32'd1);
    check({tag, "_sb"}, 32'(exp_q.size() > 0), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check({tag, "_data"}, 32'(read_data_o[p*DW +: DW]), 32'(e));
  endtask

  task automatic do_read(input int p, input logic [AW-1:0] a, input logic [DW-1:0] expv,
                         input string tag);
    exp_q.push_back(expv);
    drive(p, 1'b0, a, '0, 1'b0);
    tick();
    release_port(p);
    wait_read(p, tag);
  endtask

  initial begin
    logic ok;
    int n;
    reset_n             = 1'b0;
    address_i           = '0;
    address_valid_i     = '0;
    write_data_i        = '0;
    write_data_valid_i  = '0;
    read_write_select_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(port_ready_o), 32'h3);
    check("rst_rdv", 32'(read_data_valid_o), 32'h0);
    check("rst_wd", 32'(write_done_o), 32'h0);
    check("rst_rdata", read_data_o, 32'h0);
    check("rst_state", 32'(port_state_o), 32'h0);
    reset_n = 1'b1;
    tick();

    do_write(0, 8'h10, 16'hBEEF, "pre10");
    do_write(0, 8'h40, 16'h0007, "pre40");
    do_write(1, 8'h50, 16'h1234, "pre50");

    // 1: read latency on port 0
    exp_q.push_back(16'hBEEF);
    drive(0, 1'b0, 8'h10, '0, 1'b0);
    tick();
    release_port(0);
    check("t1_ready_e0", 32'(port_ready_o[0]), 32'd0);
    check("t1_state", 32'(port_state_o[1:0]), 32'd1);
    ok = 1'b1;
    for (int k = 1; k <= RL; k++) begin
      tick();
      if (port_ready_o[0] || read_data_valid_o[0]) ok = 1'b0;
    end
    check("t1_busy_window", 32'(ok), 32'd1);
    tick();
    check("t1_ready_done", 32'(port_ready_o[0]), 32'd1);
    wait_read(0, "t1");
    tick();
    check("t1_hold", 32'(read_data_o[DW-1:0]), 32'hBEEF);

    // 2: write latency on port 1 then read back
    drive(1, 1'b1, 8'h20, 16'h5A5A, 1'b1);
    tick();
    release_port(1);
    ok = 1'b1;
    for (int k = 1; k <= WL; k++) begin
      tick();
      if (write_done_o[1] || port_ready_o[1]) ok = 1'b0;
    end
    check("t2_busy_window", 32'(ok), 32'd1);
    tick();
    check("t2_done_e15", 32'(write_done_o[1]), 32'd1);
    check("t2_ready_e15", 32'(port_ready_o[1]), 32'd1);
    tick();
    check("t2_pulse", 32'(write_done_o[1]), 32'd0);
    do_read(1, 8'h20, 16'h5A5A, "t2_rd");

    // 3: same-edge writes to one address, port 0 wins
    drive(0, 1'b1, 8'h30, 16'h1111, 1'b1);
    drive(1, 1'b1, 8'h30, 16'h2222, 1'b1);
    tick();
    release_port(0);
    release_port(1);
    n = 0;
    while (!write_done_o[0] && n < 60) begin
      tick();
      n++;
    end
    check("t3_both_done", 32'(write_done_o), 32'h3);
    tick();
    check("t3_both_clear", 32'(write_done_o), 32'h0);
    do_read(0, 8'h30, 16'h1111, "t3_rd");

    // 4: read and write completing on the same edge, read sees old data
    drive(0, 1'b1, 8'h40, 16'h9999, 1'b1);
    tick();
    release_port(0);
    repeat (4) tick();
    exp_q.push_back(16'h0007);
    drive(1, 1'b0, 8'h40, '0, 1'b0);
    tick();
    release_port(1);
    n = 0;
    while (!read_data_valid_o[1] && n < 60) begin
      tick();
      n++;
    end
    check("t4_same_edge_wd", 32'(write_done_o[0]), 32'd1);
    wait_read(1, "t4_old");
    do_read(1, 8'h40, 16'h9999, "t4_new");

    // 5: held requests while busy, and a write without data valid
    exp_q.push_back(16'hBEEF);
    drive(0, 1'b0, 8'h10, '0, 1'b0);
    drive(1, 1'b1, 8'h20, 16'hFFFF, 1'b0);
    tick();
    ok = 1'b1;
    for (int k = 1; k <= RL; k++) begin
      address_i[AW-1:0] = AW'(k);
      tick();
      if (port_ready_o[0] || !port_ready_o[1] || write_done_o[1] ||
          port_state_o[3:2] != 2'd0) ok = 1'b0;
    end
    check("t5_busy_ignored", 32'(ok), 32'd1);
    release_port(0);
    wait_read(0, "t5");
    release_port(1);
    tick();
    check("t5_p1_idle", 32'(port_ready_o[1]), 32'd1);
    do_read(1, 8'h20, 16'h5A5A, "t5_unchanged");

    // 6: reset in the middle of a write
    drive(0, 1'b1, 8'h50, 16'hDEAD, 1'b1);
    tick();
    release_port(0);
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    check("t6_ready", 32'(port_ready_o), 32'h3);
    check("t6_state", 32'(port_state_o), 32'h0);
    check("t6_rdv", 32'(read_data_valid_o), 32'h0);
    check("t6_rdata", read_data_o, 32'h0);
    tick();
    reset_n = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < WL + 4; k++) begin
      tick();
      if (write_done_o != '0) ok = 1'b0;
    end
    check("t6_no_commit", 32'(ok), 32'd1);
`ifdef MULTIPORT_FUNCTIONAL_MEMORY_CLEAR_ON_RESET_EN
    do_read(0, 8'h50, 16'h0000, "t6_rd");
`else
    do_read(0, 8'h50, 16'h1234, "t6_rd");
`endif

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
